// File: rtl/pc_sequencer.sv
// pc_sequencer
// Registered program-counter sequencer for the fetch stage. Holds the current
// fetch address, advances it sequentially, and redirects it on resolved
// branches, jumps, returns (via a circular return-address stack) and
// exceptions. Every accepted redirect raises a multi-cycle flush pulse.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          hold pc (overridden by any accepted redirect)
//   br_valid       resolved control-flow instruction present
//   br_mode        00 jump-register, 01 branch-if-zero, 10 branch-if-nonzero,
//                  11 return
//   br_link        push return address when taken (call)
//   br_pc          address of the control-flow instruction
//   br_imm         immediate / offset
//   br_result      ALU result (condition or register operand)
//   exc_valid      exception request
//   pc             current fetch address
//   flush          squash younger instructions
//   ras_overflow   one-cycle pulse: push onto a full RAS
//   ras_underflow  one-cycle pulse: pop from an empty RAS
module pc_sequencer #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned INSTRUCTION_SIZE = 4,
  parameter logic [ADDRESS_SIZE-1:0] RESET_VECTOR = '0,
  parameter logic [ADDRESS_SIZE-1:0] EXCEPTION_VECTOR = ADDRESS_SIZE'('h100),
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    br_valid,
  input  logic [1:0]              br_mode,
  input  logic                    br_link,
  input  logic [ADDRESS_SIZE-1:0] br_pc,
  input  logic [ADDRESS_SIZE-1:0] br_imm,
  input  logic [ADDRESS_SIZE-1:0] br_result,
  input  logic                    exc_valid,
  output logic [ADDRESS_SIZE-1:0] pc,
  output logic                    flush,
  output logic                    ras_overflow,
  output logic                    ras_underflow
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [PTR_W-1:0]        PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0]        CNT_FULL   = CNT_W'(RAS_DEPTH);
  localparam logic [FC_W-1:0]         FC_LOAD    = FC_W'(FLUSH_CYCLES);
  localparam logic [ADDRESS_SIZE-1:0] INC        = ADDRESS_SIZE'(INSTRUCTION_SIZE);
  localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~(INC - ADDRESS_SIZE'(1));

  logic [ADDRESS_SIZE-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]        ras_top;
  logic [CNT_W-1:0]        ras_count;
  logic [FC_W-1:0]         flush_cnt;

  logic [ADDRESS_SIZE-1:0] pc_next;
  logic [ADDRESS_SIZE-1:0] jr_target;
  logic [ADDRESS_SIZE-1:0] rel_target;
  logic [ADDRESS_SIZE-1:0] target;
  logic [ADDRESS_SIZE-1:0] ras_wdata;
  logic [PTR_W-1:0]        ras_top_next;
  logic [PTR_W-1:0]        ras_waddr;
  logic [PTR_W-1:0]        top_inc;
  logic [PTR_W-1:0]        top_dec;
  logic [CNT_W-1:0]        ras_count_next;
  logic [FC_W-1:0]         flush_cnt_next;
  logic                    br_accept;
  logic                    taken;
  logic                    redirect;
  logic                    ras_empty;
  logic                    ras_full;
  logic                    do_push;
  logic                    do_pop;
  logic                    ras_we;
  logic                    overflow_next;
  logic                    underflow_next;

  assign flush = (flush_cnt != '0);

  always_comb begin
    // Branches arriving during a flush belong to squashed instructions;
    // an exception in the same cycle drops the branch entirely.
    br_accept  = br_valid && !flush && !exc_valid;
    jr_target  = (br_imm - INC + br_result) & ALIGN_MASK;
    rel_target = br_pc + br_imm;
    ras_empty  = (ras_count == '0);
    ras_full   = (ras_count == CNT_FULL);

    taken  = 1'b0;
    target = jr_target;
    unique case (br_mode)
      2'b00: taken = 1'b1;
      2'b01: begin
        taken  = (br_result == '0);
        target = rel_target;
      end
      2'b10: begin
        taken  = (br_result != '0);
        target = rel_target;
      end
      2'b11: begin
        taken  = 1'b1;
        target = ras_empty ? jr_target : ras_mem[ras_top];
      end
      default: taken = 1'b0;
    endcase

    redirect       = br_accept && taken;
    do_pop         = redirect && (br_mode == 2'b11) && !ras_empty;
    underflow_next = redirect && (br_mode == 2'b11) && ras_empty;
    do_push        = redirect && br_link;
    // A pop-then-push never grows the stack, so it cannot overflow.
    overflow_next  = do_push && !do_pop && ras_full;

    top_inc = (ras_top == PTR_LAST) ? '0 : ras_top + 1'b1;
    top_dec = (ras_top == '0) ? PTR_LAST : ras_top - 1'b1;

    ras_top_next   = ras_top;
    ras_count_next = ras_count;
    ras_we         = 1'b0;
    ras_waddr      = ras_top;
    ras_wdata      = br_pc + INC;
    if (do_push && do_pop) begin
      ras_we = 1'b1;
    end else if (do_push) begin
      // When full, the slot after top holds the oldest entry and is reused.
      ras_we       = 1'b1;
      ras_waddr    = top_inc;
      ras_top_next = top_inc;
      if (!ras_full) ras_count_next = ras_count + 1'b1;
    end else if (do_pop) begin
      ras_top_next   = top_dec;
      ras_count_next = ras_count - 1'b1;
    end

    if (exc_valid)     pc_next = EXCEPTION_VECTOR;
    else if (redirect) pc_next = target;
    else if (stall)    pc_next = pc;
    else               pc_next = pc + INC;

    if (exc_valid || redirect) flush_cnt_next = FC_LOAD;
    else if (flush)            flush_cnt_next = flush_cnt - 1'b1;
    else                       flush_cnt_next = flush_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_VECTOR;
      flush_cnt     <= '0;
      ras_top       <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem[i] <= '0;
    end else begin
      pc            <= pc_next;
      flush_cnt     <= flush_cnt_next;
      ras_top       <= ras_top_next;
      ras_count     <= ras_count_next;
      ras_overflow  <= overflow_next;
      ras_underflow <= underflow_next;
      if (ras_we) ras_mem[ras_waddr] <= ras_wdata;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int unsigned AW    = 32;
  localparam int unsigned IS    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FC    = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] EV    = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          br_valid;
  logic [1:0]    br_mode;
  logic          br_link;
  logic [AW-1:0] br_pc;
  logic [AW-1:0] br_imm;
  logic [AW-1:0] br_result;
  logic          exc_valid;
  logic [AW-1:0] pc;
  logic          flush;
  logic          ras_overflow;
  logic          ras_underflow;

  pc_sequencer #(
    .ADDRESS_SIZE(AW), .INSTRUCTION_SIZE(IS), .RESET_VECTOR(RV),
    .EXCEPTION_VECTOR(EV), .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
    .br_mode(br_mode), .br_link(br_link), .br_pc(br_pc), .br_imm(br_imm),
    .br_result(br_result), .exc_valid(exc_valid), .pc(pc), .flush(flush),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: fetch address, remaining flush cycles, RAS as a queue
  // (back = most recent return address).
  logic [31:0] m_pc;
  int          m_left;
  logic [31:0] m_ras[$];
  bit          m_ovf;
  bit          m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RV;
    m_left = 0;
    m_ras.delete();
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  task automatic model_step();
    logic [31:0] jr;
    logic [31:0] tgt;
    bit          tk;
    jr    = (br_imm - 32'(IS) + br_result) & ~32'(IS - 1);
    m_ovf = 0;
    m_unf = 0;
    tk    = (br_mode == 2'd0) || (br_mode == 2'd3) ||
            (br_mode == 2'd1 && br_result == 0) ||
            (br_mode == 2'd2 && br_result != 0);
    if (exc_valid) begin
      m_pc   = EV;
      m_left = FC;
    end else if (br_valid && m_left == 0 && tk) begin
      if (br_mode == 2'd3) begin
        if (m_ras.size() == 0) begin
          m_unf = 1;
          tgt   = jr;
        end else begin
          tgt = m_ras.pop_back();
        end
      end else if (br_mode == 2'd0) begin
        tgt = jr;
      end else begin
        tgt = br_pc + br_imm;
      end
      if (br_link) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back(br_pc + 32'(IS));
      end
      m_pc   = tgt;
      m_left = FC;
    end else begin
      if (!stall) m_pc = m_pc + 32'(IS);
      if (m_left > 0) m_left--;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".flush"}, 32'(flush), 32'(m_left != 0));
    check({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle();
    stall     = 0;
    br_valid  = 0;
    br_mode   = 2'd0;
    br_link   = 0;
    br_pc     = '0;
    br_imm    = '0;
    br_result = '0;
    exc_valid = 0;
  endtask

  task automatic branch(input logic [1:0] mode, input logic link, input logic [31:0] bpc,
                        input logic [31:0] imm, input logic [31:0] res);
    idle();
    br_valid  = 1;
    br_mode   = mode;
    br_link   = link;
    br_pc     = bpc;
    br_imm    = imm;
    br_result = res;
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] ret_exp [4];
    ret_exp[0] = 32'h54;
    ret_exp[1] = 32'h44;
    ret_exp[2] = 32'h34;
    ret_exp[3] = 32'h24;

    idle();
    rst_n = 0;
    #12;
    check("reset.pc", pc, RV);
    check("reset.flush", 32'(flush), 32'd0);
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1;

    // Free-running sequence.
    cycle("free");
    cycle("free");
    cycle("free");
    check("free.pc_c", pc, 32'hC);

    // Branch-if-zero taken, then not taken.
    branch(2'd1, 0, 32'h20, 32'h40, 32'h0);
    cycle("bz_taken");
    check("bz_taken.pc60", pc, 32'h60);
    idle();
    cycle("bz_flush1");
    check("bz_flush1.hi", 32'(flush), 32'd1);
    cycle("bz_flush2");
    branch(2'd1, 0, 32'h20, 32'h40, 32'h5);
    prev = pc;
    cycle("bz_not");
    check("bz_not.seq", pc, prev + 32'd4);

    // Jump-register with alignment; a branch during flush is ignored.
    branch(2'd0, 0, 32'h0, 32'h104, 32'h13);
    cycle("jr");
    check("jr.pc110", pc, 32'h110);
    branch(2'd1, 0, 32'h20, 32'h40, 32'h0);
    cycle("jr_ignored");
    check("jr_ignored.pc", pc, 32'h114);
    idle();
    cycle("jr_idle");

    // Call then return; then return on an empty RAS.
    branch(2'd0, 1, 32'h100, 32'h200, 32'h0);
    cycle("call");
    idle();
    cycle("call_f");
    cycle("call_f");
    branch(2'd3, 0, 32'h0, 32'h0, 32'h0);
    cycle("ret");
    check("ret.pc104", pc, 32'h104);
    idle();
    cycle("ret_f");
    cycle("ret_f");
    branch(2'd3, 0, 32'h0, 32'h304, 32'h0);
    cycle("ret_empty");
    check("ret_empty.unf", 32'(ras_underflow), 32'd1);
    check("ret_empty.pc", pc, 32'h300);
    idle();
    cycle("ret_empty_f");
    cycle("ret_empty_f");

    // Five calls overflow a depth-4 RAS; five returns drain it.
    for (int i = 1; i <= 5; i++) begin
      branch(2'd0, 1, 32'(i * 16), 32'h1000, 32'h0);
      cycle("calls");
      check("calls.ovf", 32'(ras_overflow), 32'(i == 5));
      idle();
      cycle("calls_f");
      cycle("calls_f");
    end
    for (int i = 0; i < 5; i++) begin
      branch(2'd3, 0, 32'h0, 32'h800, 32'h0);
      cycle("rets");
      if (i < 4) check("rets.pc", pc, ret_exp[i]);
      else check("rets.unf", 32'(ras_underflow), 32'd1);
      idle();
      cycle("rets_f");
      cycle("rets_f");
    end

    // Exception beats stall and branch; RAS untouched.
    branch(2'd0, 1, 32'h500, 32'h40, 32'h0);
    cycle("exc_call");
    idle();
    cycle("exc_call_f");
    cycle("exc_call_f");
    branch(2'd3, 0, 32'h0, 32'h0, 32'h0);
    stall     = 1;
    exc_valid = 1;
    cycle("exc");
    check("exc.pc100", pc, EV);
    idle();
    stall = 1;
    cycle("exc_stall");
    cycle("exc_stall");
    cycle("exc_stall");
    check("exc_stall.hold", pc, EV);
    branch(2'd3, 0, 32'h0, 32'h0, 32'h0);
    cycle("exc_ret");
    check("exc_ret.pc504", pc, 32'h504);
    idle();
    cycle("exc_ret_f");

    // Exception during flush reloads the flush count.
    branch(2'd0, 0, 32'h0, 32'h44, 32'h0);
    cycle("reload_br");
    idle();
    exc_valid = 1;
    cycle("reload_exc");
    idle();
    cycle("reload_f1");
    check("reload_f1.hi", 32'(flush), 32'd1);
    cycle("reload_f2");

    // Address wrap-around.
    branch(2'd1, 0, 32'hFFFF_FFF0, 32'h20, 32'h0);
    cycle("wrap");
    check("wrap.pc", pc, 32'h10);
    idle();
    cycle("wrap_f");
    cycle("wrap_f");

    // Asynchronous reset mid-flush with a non-empty RAS.
    branch(2'd0, 1, 32'h80, 32'h44, 32'h0);
    cycle("arst_br");
    idle();
    #2;
    rst_n = 0;
    #1;
    check("arst.pc", pc, RV);
    check("arst.flush", 32'(flush), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cycle("arst_rel");
    check("arst_rel.pc4", pc, RV + 32'd4);
    branch(2'd3, 0, 32'h0, 32'h24, 32'h0);
    cycle("arst_ret");
    check("arst_ret.unf", 32'(ras_underflow), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      br_valid  = ($urandom % 100) < 45;
      br_mode   = 2'($urandom % 4);
      br_link   = ($urandom % 4) == 0;
      br_pc     = $urandom & 32'hFFFF_FFFC;
      br_imm    = $urandom;
      br_result = (($urandom % 3) == 0) ? 32'h0 : $urandom;
      stall     = ($urandom % 5) == 0;
      exc_valid = ($urandom % 25) == 0;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
